// File: rtl/bus_arb_mux.sv
// Parametrised N:1 bus arbiter/multiplexer with direct or round-robin selection
// and a registered valid/ready output stage.
module bus_arb_mux #(
    parameter int WIDTH = 9,
    parameter int N     = 10,
    parameter int SELW  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N*WIDTH-1:0]   in_data,
    input  logic [N-1:0]         in_req,
    output logic [N-1:0]         in_gnt,
    input  logic                 mode,
    input  logic [SELW-1:0]      sel,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [SELW-1:0]      out_src,
    output logic                 err
);

    typedef enum logic {
        MODE_DIRECT = 1'b0,
        MODE_RR     = 1'b1
    } mode_e;

    localparam logic [SELW:0]   N_EXT   = (SELW+1)'(N);
    localparam logic [SELW-1:0] PTR_RST = SELW'(N-1);

    if ((2**SELW) < N || N < 2 || N > 16) begin : g_bad_params
        $error("bus_arb_mux: need 2 <= N <= 16 and 2**SELW >= N");
    end

    logic                load_en;
    logic                sel_ok;
    logic [SELW-1:0]     ptr;
    logic [N-1:0]        direct_oh;
    logic [N-1:0]        above_ptr;
    logic [N-1:0]        rr_masked;
    logic [N-1:0]        rr_oh;
    logic [N-1:0]        cand_oh;
    logic                pick_any;
    logic [SELW-1:0]     pick_idx;
    logic [WIDTH-1:0]    pick_data;

    // Isolates the lowest set bit: v & -v.
    function automatic logic [N-1:0] lowest_set(input logic [N-1:0] v);
        return v & (~v + N'(1));
    endfunction

    assign load_en = !out_valid || out_ready;
    assign sel_ok  = {1'b0, sel} < N_EXT;

    // NOTE: every signal driven in always_comb gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        direct_oh = '0;
        above_ptr = '0;
        for (int i = 0; i < N; i++) begin
            direct_oh[i] = in_req[i] && (SELW'(i) == sel);
            above_ptr[i] = SELW'(i) > ptr;
        end
    end

    // Requests strictly above ptr win first; otherwise wrap to the lowest requester.
    assign rr_masked = in_req & above_ptr;
    assign rr_oh     = (|rr_masked) ? lowest_set(rr_masked) : lowest_set(in_req);

    assign cand_oh  = (mode == MODE_RR) ? rr_oh : direct_oh;
    assign pick_any = |cand_oh;
    assign in_gnt   = (load_en && !rst) ? cand_oh : '0;

    // cand_oh is one-hot, so OR-reduction acts as both encoder and data mux.
    always_comb begin
        pick_idx  = '0;
        pick_data = '0;
        for (int i = 0; i < N; i++) begin
            if (cand_oh[i]) begin
                pick_idx  = pick_idx | SELW'(i);
                pick_data = pick_data | in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            out_src   <= '0;
            err       <= 1'b0;
            ptr       <= PTR_RST;
        end else begin
            err <= load_en && (mode == MODE_DIRECT) && !sel_ok;
            if (load_en) begin
                out_valid <= pick_any;
                if (pick_any) begin
                    out_data <= pick_data;
                    out_src  <= pick_idx;
                    if (mode == MODE_RR) begin
                        ptr <= pick_idx;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_bus_arb_mux.sv
// Self-checking bench for bus_arb_mux: directed scenarios followed by random
// traffic, compared against a cycle-level behavioural model.
module tb_bus_arb_mux;

    localparam int N     = 10;
    localparam int WIDTH = 9;
    localparam int SELW  = 4;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [N*WIDTH-1:0]   in_data = '0;
    logic [N-1:0]         in_req = '0;
    logic [N-1:0]         in_gnt;
    logic                 mode = 1'b0;
    logic [SELW-1:0]      sel = '0;
    logic [WIDTH-1:0]     out_data;
    logic                 out_valid;
    logic                 out_ready = 1'b1;
    logic [SELW-1:0]      out_src;
    logic                 err;

    int n_cmp = 0;
    int n_err = 0;

    // Behavioural model state
    bit               mv;
    logic [WIDTH-1:0] md;
    int               ms;
    bit               merr;
    int               mptr;

    bus_arb_mux #(.WIDTH(WIDTH), .N(N), .SELW(SELW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_req    (in_req),
        .in_gnt    (in_gnt),
        .mode      (mode),
        .sel       (sel),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_src   (out_src),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mv   = 1'b0;
        md   = '0;
        ms   = 0;
        merr = 1'b0;
        mptr = N - 1;
    endtask

    task automatic set_chan(input int c, input logic [WIDTH-1:0] v);
        in_data[c*WIDTH +: WIDTH] = v;
    endtask

    function automatic bit req_bit(input int i);
        return ((in_req >> i) & N'(1)) != '0;
    endfunction

    // Channel the rules choose this cycle, or -1 when nothing is chosen.
    function automatic int model_pick();
        int s;
        s = int'(sel);
        if (!mode) begin
            if (s < N && req_bit(s)) return s;
            return -1;
        end
        for (int k = 1; k <= N; k++) begin
            int idx;
            idx = (mptr + k) % N;
            if (req_bit(idx)) return idx;
        end
        return -1;
    endfunction

    // One clock: inputs already driven after the previous falling edge.
    task automatic cycle(input string tag);
        int          c;
        bit          le;
        logic [N-1:0] eg;
        #1;
        le = !mv || out_ready;
        c  = model_pick();
        eg = '0;
        if (le && c >= 0) eg = N'(1) << c;
        check({tag, "_gnt"}, 32'(in_gnt), 32'(eg));
        @(posedge clk);
        merr = le && !mode && (int'(sel) >= N);
        if (le) begin
            if (c >= 0) begin
                mv = 1'b1;
                md = in_data[c*WIDTH +: WIDTH];
                ms = c;
                if (mode) mptr = c;
            end else begin
                mv = 1'b0;
            end
        end
        @(negedge clk);
        check({tag, "_valid"}, 32'(out_valid), 32'(mv));
        check({tag, "_data"},  32'(out_data),  32'(md));
        check({tag, "_src"},   32'(out_src),   32'(ms));
        check({tag, "_err"},   32'(err),       32'(merr));
    endtask

    initial begin
        model_reset();
        for (int i = 0; i < N; i++) set_chan(i, WIDTH'(i * 37 + 1));

        // Reset state
        @(negedge clk);
        in_req = '1;
        #1;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_data",  32'(out_data),  32'd0);
        check("rst_src",   32'(out_src),   32'd0);
        check("rst_err",   32'(err),       32'd0);
        check("rst_gnt",   32'(in_gnt),    32'd0);
        @(negedge clk);
        rst = 1'b0;
        in_req = '0;

        // 1: direct select, legacy behaviour
        mode = 1'b0; sel = 4'd3; in_req = 10'h008; out_ready = 1'b1;
        set_chan(3, 9'h1A5);
        #1;
        check("t1_gnt_now", 32'(in_gnt), 32'h008);
        cycle("t1");
        check("t1_out", 32'(out_data), 32'h1A5);
        in_req = '0;
        cycle("t1_idle");

        // 2: out-of-range select pulses err per evaluating cycle
        sel = 4'd12; in_req = '1;
        cycle("t2a");
        check("t2_err", 32'(err), 32'd1);
        cycle("t2b");
        sel = 4'd3; in_req = '0;
        cycle("t2_clear");

        // 3: backpressure holds the word, mode/sel changes ignored
        sel = 4'd5; in_req = '1; set_chan(5, 9'h0F0);
        cycle("t3_cap");
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            mode = k[0];
            sel  = SELW'(k);
            cycle("t3_hold");
            check("t3_hold_data", 32'(out_data), 32'h0F0);
            check("t3_hold_src",  32'(out_src),  32'd5);
        end
        mode = 1'b0; sel = 4'd6; out_ready = 1'b1;
        cycle("t3_release");
        check("t3_new_src", 32'(out_src), 32'd6);
        check("t3_still_valid", 32'(out_valid), 32'd1);

        // 4: round-robin fairness from the reset pointer
        mode = 1'b1; in_req = 10'h3FF;
        for (int k = 0; k < 12; k++) begin
            cycle("t4");
            check("t4_order", 32'(out_src), 32'(k % N));
        end

        // 5: sparse wrap, direct grant does not move the pointer
        in_req = 10'h084;
        cycle("t5a"); check("t5a_src", 32'(out_src), 32'd2);
        cycle("t5b"); check("t5b_src", 32'(out_src), 32'd7);
        cycle("t5c"); check("t5c_src", 32'(out_src), 32'd2);
        cycle("t5d"); check("t5d_src", 32'(out_src), 32'd7);
        mode = 1'b0; sel = 4'd2;
        cycle("t5_direct"); check("t5_direct_src", 32'(out_src), 32'd2);
        mode = 1'b1;
        cycle("t5e"); check("t5e_src", 32'(out_src), 32'd2);
        cycle("t5f"); check("t5f_src", 32'(out_src), 32'd7);

        // 6: async reset while a word is held
        out_ready = 1'b0;
        cycle("t6_hold");
        #2;
        rst = 1'b1;
        #1;
        check("t6_rst_valid", 32'(out_valid), 32'd0);
        check("t6_rst_data",  32'(out_data),  32'd0);
        check("t6_rst_gnt",   32'(in_gnt),    32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        mode = 1'b1; in_req = 10'h3FF; out_ready = 1'b1;
        cycle("t6_first");
        check("t6_first_src", 32'(out_src), 32'd0);

        // Random traffic against the model
        for (int k = 0; k < 600; k++) begin
            mode      = $urandom_range(0, 1) != 0;
            sel       = SELW'($urandom_range(0, 15));
            in_req    = N'($urandom);
            out_ready = $urandom_range(0, 3) != 0;
            for (int i = 0; i < N; i++) set_chan(i, WIDTH'($urandom));
            cycle("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
